mmio_msg_bridge: RTL and testbench
==================================

# mmio_msg_bridge

Memory-mapped message bridge between the picorv32 native memory bus and a ready/valid stream port toward the NoC router. It replaces the single-cycle, unbuffered output registers (byte, matrix element, end-of-row/end-of-matrix strobes, position) and the unsynchronised input byte with buffered TX and RX paths. Width, FIFO depths and destination width are parametrised, and both directions apply back-pressure. Sits beside the firmware RAM in the system top; the top ORs its `mem_ready`/`mem_rdata` with the RAM's.

## Interface
- `BASE_ADDR`, 32'h4000_0000, base of the 256-byte register window; bits [7:0] must be zero.
- `DATA_W`, 32, stream data width, 8..32.
- `DEST_W`, 8, destination field width, 1..16.
- `TX_DEPTH`, 8, TX FIFO entries, power of two, ≥2.
- `RX_DEPTH`, 8, RX FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `mem_valid` in 1: core bus request.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte strobes; zero means read.
- `mem_ready` out 1: access complete. Asserted only for in-window accesses.
- `mem_rdata` out 32: read data. Zero whenever `mem_ready` is low.
- `tx_valid`, `tx_ready` out/in 1: outbound handshake.
- `tx_data` out DATA_W; `tx_last` out 1; `tx_dest` out DEST_W: outbound payload.
- `rx_valid`, `rx_ready` in/out 1: inbound handshake.
- `rx_data` in DATA_W; `rx_last` in 1: inbound payload.
- `irq` out 1: present only with `MSG_BRIDGE_IRQ_EN`.

## Operation
- An access is selected when `mem_valid && mem_addr[31:8]==BASE_ADDR[31:8]`. Offsets are `mem_addr[7:0]`.
- 0x00 TX_DATA (W): pushes `{mem_wdata[DATA_W-1:0], last=0, dest=DEST}`.
- 0x04 TX_LAST (W): same push with last=1.
- 0x08 RX_DATA (R): pops. Returns `{rx_last_bit at [31] when DATA_W<32, data zero-extended}`. When DATA_W==32, last is readable only via STATUS.
- 0x0C STATUS (R): [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] rx_underflow (sticky), [5] head-of-RX last, [15:8] tx_count, [23:16] rx_count.
- 0x10 DEST (R/W): byte-strobed, low DEST_W bits kept.
- 0x14 CTRL (R/W): [0] irq_en, [1] write 1 clears rx_underflow (self-clearing, reads 0).
- Any nonzero `mem_wstrb` to TX_DATA/TX_LAST pushes the full word.
- Writes to read-only or unmapped offsets: ignored, acknowledged. Reads of unmapped offsets return 0.
- Write to TX while tx_full: `mem_ready` held low (core stalls) until a slot frees, then the push completes.
- Read of RX_DATA while rx_empty: returns 0, sets rx_underflow, no stall.
- `rx_ready = !rx_full`. `tx_valid = !tx_empty`. Both FIFOs are first-word-fall-through.
- Reset: all outputs 0, FIFOs empty, DEST=0, CTRL=0, rx_underflow=0. Reset mid-transfer discards FIFO contents; no partial handshake survives.

## Timing
- Bus: `mem_ready` pulses 1 cycle after a selected `mem_valid` (registered). It is held one cycle only; the bridge never acknowledges the same request twice (a `!mem_ready` guard).
- Push/pop take effect on the `mem_ready` cycle edge. STATUS read on the next access reflects them.
- Full/empty flags are registered counts. A write arriving while full stalls at least one cycle even if `tx_ready` pops that same cycle.
- Stream: a transfer occurs on an edge with valid&&ready. `tx_data/last/dest` are stable while `tx_valid && !tx_ready`.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers wrap modulo depth. The count is $clog2(depth)+1 bits wide.

## Configuration
- `MSG_BRIDGE_IRQ_EN` defined: `irq` port exists; `irq` is registered `irq_en && !rx_empty`, one-cycle latency after the flag changes.
- Undefined: no port; CTRL[0] reads 0 and writes are ignored.

## Structure
- `mmio_msg_bridge_pkg` holds the register offset localparams, STATUS/CTRL bit indices, and the TX entry struct `{data, last, dest}`.
- One sub-module `sync_fifo` (params WIDTH, DEPTH; FWFT; count/full/empty outputs), instantiated for TX and RX.

## Test plan
- Reset, then read STATUS -> 0x0000_0006 (tx_empty, rx_empty). All stream outputs 0.
- DEST=0x05; write 0x11, 0x22, then TX_LAST 0x33 with `tx_ready=1` -> three beats with dest 0x05, last only on 0x33, in order.
- `tx_ready=0`; write 9 words (TX_DEPTH=8) -> ninth write stalls `mem_ready`. Raise `tx_ready` for one beat -> stall releases and the ninth word appears ninth.
- Drive RX beats 0xA5 and 0x5A(last) -> STATUS rx_count=2, bit5=0. Read RX_DATA -> 0xA5, then 0x8000_005A.
- Read RX_DATA while empty -> 0, STATUS bit4=1. CTRL write 0x2 -> bit4 cleared.
- With `MSG_BRIDGE_IRQ_EN`, irq_en=1: one RX beat -> `irq` high next cycle; pop it -> `irq` low. Assert `resetn` low with 3 entries queued -> empty, all outputs 0.

Source files
------------

// File: rtl/mmio_msg_bridge_pkg.sv
// mmio_msg_bridge shared definitions: register map,
// STATUS/CTRL bit positions and the TX FIFO entry layout.
package mmio_msg_bridge_pkg;

  localparam logic [7:0] OFF_TX_DATA = 8'h00;
  localparam logic [7:0] OFF_TX_LAST = 8'h04;
  localparam logic [7:0] OFF_RX_DATA = 8'h08;
  localparam logic [7:0] OFF_STATUS  = 8'h0C;
  localparam logic [7:0] OFF_DEST    = 8'h10;
  localparam logic [7:0] OFF_CTRL    = 8'h14;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_UFLOW = 4;
  localparam int ST_RX_LAST  = 5;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 16;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_UF_CLR  = 1;

  // Sized for the widest legal DATA_W/DEST_W; unused bits stay zero.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [15:0] dest;
  } tx_entry_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered
// occupancy count; full/empty derive from the count register.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push}
                 - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mmio_msg_bridge.sv
// picorv32 MMIO <-> NoC stream bridge with buffered TX/RX.
// Define MSG_BRIDGE_IRQ_EN to add the irq output and CTRL[0].
module mmio_msg_bridge
  import mmio_msg_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int DATA_W   = 32,
  parameter int DEST_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic [DEST_W-1:0] tx_dest,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_last
`ifdef MSG_BRIDGE_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int TXC_W = $clog2(TX_DEPTH) + 1;
  localparam int RXC_W = $clog2(RX_DEPTH) + 1;
  localparam int TXE_W = $bits(tx_entry_t);

  logic [7:0]        off;
  logic              sel;
  logic              wr;
  logic              is_tx;
  logic              accept;
  logic              tx_push;
  logic              rx_pop;
  logic              uflow_set;
  logic              uflow_clr;
  logic              dest_wr;
  logic              ctrl_wr;
  logic              irq_en;

  logic [DEST_W-1:0] dest_q;
  logic [31:0]       dest_wide;
  logic              uflow_q;

  tx_entry_t         tx_in;
  tx_entry_t         tx_head;
  logic [TXC_W-1:0]  tx_count;
  logic              tx_full;
  logic              tx_empty;

  logic [DATA_W:0]   rx_head;
  logic [RXC_W-1:0]  rx_count;
  logic              rx_full;
  logic              rx_empty;

  logic [31:0]       rx_word;
  logic [31:0]       status;
  logic [31:0]       ctrl_rd;
  logic [31:0]       rd_val;

  assign off = mem_addr[7:0];
  assign sel = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign wr  = |mem_wstrb;

  assign is_tx = wr && (off == OFF_TX_DATA || off == OFF_TX_LAST);

  // A TX write waits on the registered full flag, so it always
  // stalls at least one cycle once the FIFO has filled.
  assign accept    = sel && !mem_ready && !(is_tx && tx_full);
  assign tx_push   = accept && is_tx;
  assign rx_pop    = accept && !wr && off == OFF_RX_DATA && !rx_empty;
  assign uflow_set = accept && !wr && off == OFF_RX_DATA && rx_empty;
  assign dest_wr   = accept && wr && off == OFF_DEST;
  assign ctrl_wr   = accept && wr && off == OFF_CTRL;
  assign uflow_clr = ctrl_wr && mem_wstrb[0] && mem_wdata[CTRL_UF_CLR];

  assign dest_wide = strb_merge(32'(dest_q), mem_wdata, mem_wstrb);

  always_comb begin
    tx_in = '0;
    tx_in.data[DATA_W-1:0] = mem_wdata[DATA_W-1:0];
    tx_in.last = (off == OFF_TX_LAST);
    tx_in.dest[DEST_W-1:0] = dest_q;
  end

  sync_fifo #(
    .WIDTH (TXE_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tx_push),
    .din    (tx_in),
    .pop    (tx_valid && tx_ready),
    .dout   (tx_head),
    .count  (tx_count),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (rx_valid && rx_ready),
    .din    ({rx_last, rx_data}),
    .pop    (rx_pop),
    .dout   (rx_head),
    .count  (rx_count),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  // Payload is gated so stale storage never shows after reset.
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_valid ? tx_head.data[DATA_W-1:0] : '0;
  assign tx_last  = tx_valid && tx_head.last;
  assign tx_dest  = tx_valid ? tx_head.dest[DEST_W-1:0] : '0;
  assign rx_ready = !rx_full;

  always_comb begin
    rx_word = '0;
    if (!rx_empty) begin
      rx_word[DATA_W-1:0] = rx_head[DATA_W-1:0];
      if (DATA_W < 32) rx_word[31] = rx_head[DATA_W];
    end
  end

  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_UFLOW] = uflow_q;
    status[ST_RX_LAST]  = !rx_empty && rx_head[DATA_W];
    status[ST_TX_CNT +: 8] = 8'(tx_count);
    status[ST_RX_CNT +: 8] = 8'(rx_count);
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_IRQ_EN] = irq_en;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      off == OFF_RX_DATA: rd_val = rx_word;
      off == OFF_STATUS:  rd_val = status;
      off == OFF_DEST:    rd_val = 32'(dest_q);
      off == OFF_CTRL:    rd_val = ctrl_rd;
      default:            rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      dest_q    <= '0;
      uflow_q   <= 1'b0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !wr) ? rd_val : '0;
      if (dest_wr) dest_q <= dest_wide[DEST_W-1:0];
      if (uflow_set)      uflow_q <= 1'b1;
      else if (uflow_clr) uflow_q <= 1'b0;
    end
  end

`ifdef MSG_BRIDGE_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr && mem_wstrb[0])
        irq_en_q <= mem_wdata[CTRL_IRQ_EN];
      irq <= irq_en_q && !rx_empty;
    end
  end

  assign irq_en = irq_en_q;
`else
  assign irq_en = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{dest_wide, tx_head};

endmodule

// File: tb/tb_mmio_msg_bridge.sv
// Scoreboard bench for mmio_msg_bridge (DATA_W=8, DEST_W=8,
// depth 8); irq checks are compiled in with MSG_BRIDGE_IRQ_EN.
module tb_mmio_msg_bridge;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TXD = BASE + 32'h00;
  localparam logic [31:0] A_TXL = BASE + 32'h04;
  localparam logic [31:0] A_RXD = BASE + 32'h08;
  localparam logic [31:0] A_ST  = BASE + 32'h0C;
  localparam logic [31:0] A_DST = BASE + 32'h10;
  localparam logic [31:0] A_CTL = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic [7:0]  tx_dest;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = '0;
  logic        rx_last = 1'b0;
`ifdef MSG_BRIDGE_IRQ_EN
  logic        irq;
`endif

  mmio_msg_bridge #(
    .BASE_ADDR (BASE),
    .DATA_W    (8),
    .DEST_W    (8),
    .TX_DEPTH  (8),
    .RX_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_dest   (tx_dest),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_last   (rx_last)
`ifdef MSG_BRIDGE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q[$];
  logic [16:0] tx_q[$];
  bit cur_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit is_rd);
    bit ok = 1'b0;
    @(negedge clk);
    cur_rd    = is_rd;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: addr %h no mem_ready", a);
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s = 4'hF);
    access(a, d, s, 1'b0);
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    access(a, '0, 4'h0, 1'b1);
  endtask

  task automatic tx_push(input logic [7:0] d, input bit last,
                         input logic [7:0] dest);
    tx_q.push_back({d, last, dest});
    bus_wr(last ? A_TXL : A_TXD, {24'h0, d});
  endtask

  task automatic rx_beat(input logic [7:0] d, input bit last);
    bit ok = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_last  = last;
    for (int i = 0; i < 32; i++) begin
      if (rx_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: beat %h not accepted", d);
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  // Bus read monitor.
  initial forever begin
    @(negedge clk);
    #1;
    if (mem_ready) begin
      if (!cur_rd) begin
        chk("wr_ack_rdata", mem_rdata, 32'h0);
      end else if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %h expected none", mem_rdata);
      end else begin
        chk("bus_rd", mem_rdata, rd_q.pop_front());
      end
    end
  end

  // Stream transmit monitor.
  initial forever begin
    @(negedge clk);
    #1;
    if (resetn && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %h expected none",
                 {tx_data, tx_last, tx_dest});
      end else begin
        chk("tx_beat", 32'({tx_data, tx_last, tx_dest}),
            32'(tx_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_payload", {15'h0, tx_data, tx_last, tx_dest}, 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_mem_rdata", mem_rdata, 0);
`ifdef MSG_BRIDGE_IRQ_EN
    chk("rst_irq", 32'(irq), 0);
`endif
    resetn = 1'b1;
    bus_rd(A_ST, 32'h0000_0006);

    // Ordered TX with destination
    bus_wr(A_DST, 32'h0000_0005);
    bus_rd(A_DST, 32'h0000_0005);
    bus_wr(A_DST, 32'h0000_AB00, 4'b0010);
    bus_rd(A_DST, 32'h0000_0005);
    tx_ready = 1'b1;
    tx_push(8'h11, 1'b0, 8'h05);
    tx_push(8'h22, 1'b0, 8'h05);
    tx_push(8'h33, 1'b1, 8'h05);
    repeat (4) @(negedge clk);
    tx_ready = 1'b0;
    bus_rd(A_ST, 32'h0000_0006);

    // Fill TX, ninth write stalls until one beat drains
    for (int i = 0; i < 8; i++) tx_push(8'(8'h40 + i), 1'b0, 8'h05);
    bus_rd(A_ST, 32'h0000_0805);
    tx_q.push_back({8'h48, 1'b0, 8'h05});
    @(negedge clk);
    cur_rd    = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = A_TXD;
    mem_wdata = 32'h48;
    mem_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_ready_low", 32'(mem_ready), 0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (mem_ready) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("stall_release", 32'(seen), 1);
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
    bus_rd(A_ST, 32'h0000_0805);
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && tx_valid; i++) @(negedge clk);
    tx_ready = 1'b0;
    chk("tx_drained", 32'(tx_valid), 0);

    // Register map corners
    bus_wr(A_ST, 32'hFFFF_FFFF);
    bus_wr(BASE + 32'h20, 32'h1234_5678);
    bus_rd(BASE + 32'h20, 32'h0);
    bus_rd(A_ST, 32'h0000_0006);
    @(negedge clk);
    cur_rd    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("out_of_window", {31'h0, mem_ready} | mem_rdata, 0);
    end
    mem_valid = 1'b0;

    // RX path, last flag, underflow
    rx_beat(8'hA5, 1'b0);
    rx_beat(8'h5A, 1'b1);
    bus_rd(A_ST, 32'h0002_0002);
    bus_rd(A_RXD, 32'h0000_00A5);
    bus_rd(A_ST, 32'h0001_0022);
    bus_rd(A_RXD, 32'h8000_005A);
    bus_rd(A_ST, 32'h0000_0006);
    bus_rd(A_RXD, 32'h0000_0000);
    bus_rd(A_ST, 32'h0000_0016);
    bus_wr(A_CTL, 32'h0000_0002);
    bus_rd(A_ST, 32'h0000_0006);
    bus_rd(A_CTL, 32'h0);

`ifdef MSG_BRIDGE_IRQ_EN
    bus_wr(A_CTL, 32'h1);
    bus_rd(A_CTL, 32'h1);
    rx_beat(8'h77, 1'b0);
    @(negedge clk);
    chk("irq_high", 32'(irq), 1);
    bus_rd(A_RXD, 32'h0000_0077);
    repeat (2) @(negedge clk);
    chk("irq_low", 32'(irq), 0);
    bus_wr(A_CTL, 32'h0);
`else
    bus_wr(A_CTL, 32'h1);
    bus_rd(A_CTL, 32'h0);
`endif

    // Reset with traffic queued
    for (int i = 0; i < 3; i++) bus_wr(A_TXD, 32'(8'hC0 + i));
    rx_beat(8'h99, 1'b1);
    bus_rd(A_ST, 32'h0001_0320);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_payload", {15'h0, tx_data, tx_last, tx_dest}, 0);
    chk("mid_rst_ready", 32'(mem_ready), 0);
    @(negedge clk);
    resetn = 1'b1;
    bus_rd(A_ST, 32'h0000_0006);
    bus_rd(A_DST, 32'h0);

    repeat (4) @(negedge clk);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
